// File: rtl/weight_load_controller_if.sv
// Bundle of command, weight-memory and array-side signals for the weight load controller.
// The master modport is the controller's view; the slave modport is the surrounding system's view.
interface weight_load_controller_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  num_tiles;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_weight1;
   logic [DATA_W-1:0] mem_weight2;
   logic [DATA_W-1:0] mem_weight3;
   logic [DATA_W-1:0] mem_weight4;
   logic [DATA_W-1:0] w11;
   logic [DATA_W-1:0] w12;
   logic [DATA_W-1:0] w21;
   logic [DATA_W-1:0] w22;
   logic              load_weight;
   logic              array_ready;
   logic [CNT_W-1:0]  tiles_loaded;
   logic              busy;
   logic              done;

   modport master (
      input  start, abort, base_addr, num_tiles,
      input  mem_weight1, mem_weight2, mem_weight3, mem_weight4,
      input  array_ready,
      output mem_addr, w11, w12, w21, w22, load_weight, tiles_loaded, busy, done
   );

   modport slave (
      output start, abort, base_addr, num_tiles,
      output mem_weight1, mem_weight2, mem_weight3, mem_weight4,
      output array_ready,
      input  mem_addr, w11, w12, w21, w22, load_weight, tiles_loaded, busy, done
   );
endinterface

// File: rtl/weight_load_controller.sv
// Weight load controller: walks weight memory four weights at a time and hands each
// 2x2 tile to the systolic array over a valid/ready handshake. Outputs come from
// registers or are decoded from state only.
module weight_load_controller #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   weight_load_controller_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [ADDR_W-1:0] r_mem_addr;
   logic [CNT_W-1:0]  r_num_tiles;
   logic [CNT_W-1:0]  r_tiles_loaded;
   logic [DATA_W-1:0] r_w11;
   logic [DATA_W-1:0] r_w12;
   logic [DATA_W-1:0] r_w21;
   logic [DATA_W-1:0] r_w22;

   logic              w_accept;
   logic              w_capture;
   logic              w_xfer;
   logic              w_last;
   logic [CNT_W-1:0]  w_tiles_inc;

   assign w_accept    = (r_state == S_IDLE) && bus.start;
   assign w_capture   = (r_state == S_FETCH) && !bus.abort;
   // abort beats a simultaneous handshake: the tile is not counted
   assign w_xfer      = (r_state == S_LOAD) && bus.array_ready && !bus.abort;
   assign w_tiles_inc = r_tiles_loaded + 1'b1;
   assign w_last      = (w_tiles_inc == r_num_tiles);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next_state = (bus.num_tiles != '0) ? S_FETCH : S_DONE;
            end
         end
         S_FETCH: begin
            w_next_state = bus.abort ? S_IDLE : S_LOAD;
         end
         S_LOAD: begin
            if (bus.abort) begin
               w_next_state = S_IDLE;
            end else if (bus.array_ready) begin
               w_next_state = w_last ? S_DONE : S_FETCH;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Address, tile counter and captured weight registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_addr     <= '0;
         r_num_tiles    <= '0;
         r_tiles_loaded <= '0;
         r_w11          <= '0;
         r_w12          <= '0;
         r_w21          <= '0;
         r_w22          <= '0;
      end else begin
         if (w_accept) begin
            r_tiles_loaded <= '0;
            // a zero-tile command completes without touching memory
            if (bus.num_tiles != '0) begin
               r_mem_addr  <= bus.base_addr;
               r_num_tiles <= bus.num_tiles;
            end
         end
         if (w_capture) begin
            r_w11 <= bus.mem_weight1;
            r_w12 <= bus.mem_weight2;
            r_w21 <= bus.mem_weight3;
            r_w22 <= bus.mem_weight4;
         end
         if (w_xfer) begin
            r_tiles_loaded <= w_tiles_inc;
            r_mem_addr     <= r_mem_addr + ADDR_W'(4);
         end
      end
   end

   assign bus.mem_addr     = r_mem_addr;
   assign bus.w11          = r_w11;
   assign bus.w12          = r_w12;
   assign bus.w21          = r_w21;
   assign bus.w22          = r_w22;
   assign bus.tiles_loaded = r_tiles_loaded;
   assign bus.load_weight  = (r_state == S_LOAD);
   assign bus.busy         = (r_state == S_FETCH) || (r_state == S_LOAD);
   assign bus.done         = (r_state == S_DONE);

endmodule

// File: tb/tb_weight_load_controller.sv
// Directed testbench for weight_load_controller with a combinational weight memory model.
module tb_weight_load_controller;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   weight_load_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   weight_load_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [ADDR_W-1:0] a1, a2, a3;
   assign a1 = bus.mem_addr + 13'd1;
   assign a2 = bus.mem_addr + 13'd2;
   assign a3 = bus.mem_addr + 13'd3;
   assign bus.mem_weight1 = mem[bus.mem_addr];
   assign bus.mem_weight2 = mem[a1];
   assign bus.mem_weight3 = mem[a2];
   assign bus.mem_weight4 = mem[a3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.array_ready = 1'b0;
      bus.base_addr = '0; bus.num_tiles = '0;
      tick(); tick(); tick();
      checks++;
      if ({bus.load_weight, bus.busy, bus.done} !== 3'b000) begin
         $display("FAIL reset_flags got=%b exp=000", {bus.load_weight, bus.busy, bus.done});
         failures++;
      end
      checks++;
      if ({bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h0) begin
         $display("FAIL reset_weights got=%h exp=00000000", {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      checks++;
      if (bus.mem_addr !== 13'd0 || bus.tiles_loaded !== 8'd0) begin
         $display("FAIL reset_addr_cnt got addr=%0d tiles=%0d exp 0/0", bus.mem_addr, bus.tiles_loaded);
         failures++;
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      // cycle 0
      bus.start = 1'b1; bus.base_addr = 13'd0; bus.num_tiles = 8'd2; bus.array_ready = 1'b1;
      tick(); // cycle 1
      bus.start = 1'b0; bus.base_addr = 13'd100; bus.num_tiles = 8'd9;
      checks++;
      if ({bus.busy, bus.load_weight, bus.done} !== 3'b100 || bus.mem_addr !== 13'd0) begin
         $display("FAIL basic_fetch1 got bld=%b addr=%0d exp bld=100 addr=0",
                  {bus.busy, bus.load_weight, bus.done}, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 2
      checks++;
      if (bus.load_weight !== 1'b1 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h01020304) begin
         $display("FAIL basic_load1 got lw=%b w=%h exp lw=1 w=01020304",
                  bus.load_weight, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 3
      checks++;
      if (bus.load_weight !== 1'b0 || bus.busy !== 1'b1 || bus.tiles_loaded !== 8'd1 || bus.mem_addr !== 13'd4) begin
         $display("FAIL basic_fetch2 got lw=%b busy=%b tiles=%0d addr=%0d exp 0/1/1/4",
                  bus.load_weight, bus.busy, bus.tiles_loaded, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 4
      checks++;
      if (bus.load_weight !== 1'b1 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h05060708) begin
         $display("FAIL basic_load2 got lw=%b w=%h exp lw=1 w=05060708",
                  bus.load_weight, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 5
      // a start during DONE must be ignored
      bus.start = 1'b1; bus.num_tiles = 8'd1; bus.base_addr = 13'd0;
      checks++;
      if ({bus.done, bus.busy, bus.load_weight} !== 3'b100 || bus.tiles_loaded !== 8'd2 || bus.mem_addr !== 13'd8) begin
         $display("FAIL basic_done got dbl=%b tiles=%0d addr=%0d exp dbl=100 tiles=2 addr=8",
                  {bus.done, bus.busy, bus.load_weight}, bus.tiles_loaded, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 6
      bus.start = 1'b0;
      checks++;
      if ({bus.done, bus.busy} !== 2'b00 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h05060708) begin
         $display("FAIL basic_after_done got db=%b w=%h exp db=00 w=05060708",
                  {bus.done, bus.busy}, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // still idle after the ignored start
      checks++;
      if (bus.busy !== 1'b0 || bus.mem_addr !== 13'd8) begin
         $display("FAIL start_in_done_ignored got busy=%b addr=%0d exp 0/8", bus.busy, bus.mem_addr);
         failures++;
      end
   endtask

   task automatic test_stall();
      bus.start = 1'b1; bus.base_addr = 13'd0; bus.num_tiles = 8'd2; bus.array_ready = 1'b0;
      tick(); // cycle 1
      bus.start = 1'b0;
      for (int c = 2; c <= 5; c++) begin
         tick();
         checks++;
         if (bus.load_weight !== 1'b1 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h01020304 ||
             bus.tiles_loaded !== 8'd0) begin
            $display("FAIL stall_hold c=%0d got lw=%b w=%h tiles=%0d exp lw=1 w=01020304 tiles=0",
                     c, bus.load_weight, {bus.w11, bus.w12, bus.w21, bus.w22}, bus.tiles_loaded);
            failures++;
         end
      end
      tick(); // cycle 6
      bus.array_ready = 1'b1;
      checks++;
      if (bus.load_weight !== 1'b1 || bus.mem_addr !== 13'd0) begin
         $display("FAIL stall_c6 got lw=%b addr=%0d exp 1/0", bus.load_weight, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 7
      checks++;
      if (bus.load_weight !== 1'b0 || bus.tiles_loaded !== 8'd1) begin
         $display("FAIL stall_c7 got lw=%b tiles=%0d exp 0/1", bus.load_weight, bus.tiles_loaded);
         failures++;
      end
      tick(); // cycle 8
      tick(); // cycle 9
      checks++;
      if (bus.done !== 1'b1 || bus.tiles_loaded !== 8'd2) begin
         $display("FAIL stall_done got done=%b tiles=%0d exp 1/2", bus.done, bus.tiles_loaded);
         failures++;
      end
      tick();
   endtask

   task automatic test_wrap();
      bus.start = 1'b1; bus.base_addr = 13'd8188; bus.num_tiles = 8'd2; bus.array_ready = 1'b1;
      tick(); // cycle 1
      bus.start = 1'b0;
      tick(); // cycle 2
      checks++;
      if ({bus.w11, bus.w12, bus.w21, bus.w22} !== 32'hA1A2A3A4) begin
         $display("FAIL wrap_tile1 got w=%h exp a1a2a3a4", {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 3
      checks++;
      if (bus.mem_addr !== 13'd0 || bus.busy !== 1'b1) begin
         $display("FAIL wrap_fetch2 got addr=%0d busy=%b exp 0/1", bus.mem_addr, bus.busy);
         failures++;
      end
      tick(); // cycle 4
      checks++;
      if ({bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h01020304) begin
         $display("FAIL wrap_tile2 got w=%h exp 01020304", {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 5
      checks++;
      if (bus.done !== 1'b1 || bus.mem_addr !== 13'd4) begin
         $display("FAIL wrap_done got done=%b addr=%0d exp 1/4", bus.done, bus.mem_addr);
         failures++;
      end
      tick();
   endtask

   task automatic test_zero_tiles();
      bus.start = 1'b1; bus.base_addr = 13'd40; bus.num_tiles = 8'd0; bus.array_ready = 1'b1;
      tick(); // cycle 1
      bus.start = 1'b0;
      checks++;
      if ({bus.done, bus.busy, bus.load_weight} !== 3'b100 || bus.tiles_loaded !== 8'd0 || bus.mem_addr !== 13'd4) begin
         $display("FAIL zero_done got dbl=%b tiles=%0d addr=%0d exp dbl=100 tiles=0 addr=4",
                  {bus.done, bus.busy, bus.load_weight}, bus.tiles_loaded, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 2
      checks++;
      if ({bus.done, bus.busy, bus.load_weight} !== 3'b000) begin
         $display("FAIL zero_after got dbl=%b exp 000", {bus.done, bus.busy, bus.load_weight});
         failures++;
      end
   endtask

   task automatic test_abort();
      bus.start = 1'b1; bus.base_addr = 13'd0; bus.num_tiles = 8'd2; bus.array_ready = 1'b1;
      tick(); // cycle 1
      bus.start = 1'b0;
      tick(); // cycle 2
      tick(); // cycle 3: start while busy must be ignored
      bus.start = 1'b1; bus.base_addr = 13'd100; bus.num_tiles = 8'd5;
      tick(); // cycle 4: second LOAD, abort with ready
      bus.start = 1'b0; bus.abort = 1'b1;
      checks++;
      if (bus.load_weight !== 1'b1 || bus.mem_addr !== 13'd4 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h05060708) begin
         $display("FAIL abort_busy_start got lw=%b addr=%0d w=%h exp 1/4/05060708",
                  bus.load_weight, bus.mem_addr, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 5
      bus.abort = 1'b0;
      checks++;
      if ({bus.busy, bus.load_weight, bus.done} !== 3'b000 || bus.tiles_loaded !== 8'd1 || bus.mem_addr !== 13'd4) begin
         $display("FAIL abort_idle got bld=%b tiles=%0d addr=%0d exp 000/1/4",
                  {bus.busy, bus.load_weight, bus.done}, bus.tiles_loaded, bus.mem_addr);
         failures++;
      end
      tick(); // cycle 6
      checks++;
      if ({bus.busy, bus.done} !== 2'b00 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h05060708) begin
         $display("FAIL abort_no_done got bd=%b w=%h exp 00/05060708",
                  {bus.busy, bus.done}, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1; bus.base_addr = 13'd0; bus.num_tiles = 8'd2; bus.array_ready = 1'b1;
      tick(); // cycle 1
      bus.start = 1'b0;
      tick(); // cycle 2: LOAD with ready, start also high; reset wins
      reset = 1'b1; bus.start = 1'b1;
      tick(); // cycle 3
      reset = 1'b0; bus.start = 1'b0;
      checks++;
      if ({bus.load_weight, bus.busy, bus.done} !== 3'b000 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h0 ||
          bus.mem_addr !== 13'd0 || bus.tiles_loaded !== 8'd0) begin
         $display("FAIL reset_mid got lbd=%b w=%h addr=%0d tiles=%0d exp all zero",
                  {bus.load_weight, bus.busy, bus.done}, {bus.w11, bus.w12, bus.w21, bus.w22},
                  bus.mem_addr, bus.tiles_loaded);
         failures++;
      end
      // fresh start after reset
      bus.start = 1'b1; bus.base_addr = 13'd4; bus.num_tiles = 8'd1;
      tick(); // cycle 1
      bus.start = 1'b0;
      tick(); // cycle 2
      checks++;
      if (bus.load_weight !== 1'b1 || {bus.w11, bus.w12, bus.w21, bus.w22} !== 32'h05060708) begin
         $display("FAIL reset_restart_load got lw=%b w=%h exp 1/05060708",
                  bus.load_weight, {bus.w11, bus.w12, bus.w21, bus.w22});
         failures++;
      end
      tick(); // cycle 3
      checks++;
      if (bus.done !== 1'b1 || bus.tiles_loaded !== 8'd1 || bus.mem_addr !== 13'd8) begin
         $display("FAIL reset_restart_done got done=%b tiles=%0d addr=%0d exp 1/1/8",
                  bus.done, bus.tiles_loaded, bus.mem_addr);
         failures++;
      end
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
      for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
      mem[8188] = 8'hA1; mem[8189] = 8'hA2; mem[8190] = 8'hA3; mem[8191] = 8'hA4;

      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero_tiles();
      test_abort();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_load_controller.md
Name: weight_load_controller

Overview:
Sequences weight tiles out of the weight memory into the systolic array's 2x2 PE weight registers. On a start command it walks the memory from a base address, four weights per tile. For each tile it captures the memory's combinational read outputs, then presents them to the array with a valid/ready handshake. Sits between the top-level control (host or instruction decoder) and the weight_memory/systolic array pair.

Parameters:
ADDR_W, 13, width of weight memory address
DATA_W, 8, width of one weight
CNT_W, 8, width of tile count and progress counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle command pulse; sampled only in IDLE
abort  input  1  cancel an in-flight load; sampled in FETCH and LOAD
base_addr  input  ADDR_W  address of first weight of first tile, latched on accepted start
num_tiles  input  CNT_W  number of 4-weight tiles to load, latched on accepted start
mem_addr  output  ADDR_W  address driven to weight memory
mem_weight1..mem_weight4  input  DATA_W each  combinational read data from memory (addr+0..addr+3)
w11, w12, w21, w22  output  DATA_W each  weights presented to the array (w11=addr+0, w12=+1, w21=+2, w22=+3)
load_weight  output  1  valid: w11..w22 hold a tile for the array
array_ready  input  1  array accepts the tile this cycle when load_weight=1
tiles_loaded  output  CNT_W  number of tiles accepted since last start
busy  output  1  high in FETCH and LOAD
done  output  1  one-cycle pulse on normal completion

Behaviour:
- One clock. Reset is synchronous and active-high. All state is updated on posedge clk.
- Reset, and reset asserted mid-operation: state=IDLE; mem_addr, w11..w22, tiles_loaded = 0; load_weight, busy, done = 0. Reset takes priority over start, abort and array_ready.
- State machine: IDLE, FETCH, LOAD, DONE. All outputs are registered or decoded from state only, so there are no combinational paths from input to output.
- IDLE:
  - start=1 and num_tiles!=0: latch base_addr into mem_addr, latch num_tiles, clear tiles_loaded, go to FETCH.
  - start=1 and num_tiles==0: clear tiles_loaded, go to DONE with no memory access.
- FETCH (one cycle): mem_addr is stable. At the clock edge, capture mem_weight1..4 into w11,w12,w21,w22, then go to LOAD.
- LOAD:
  - load_weight=1; w11..w22 are held stable.
  - Transfer occurs when load_weight and array_ready are both 1. On transfer: tiles_loaded += 1 and mem_addr += 4, modulo 2^ADDR_W (wraps 8188 -> 0).
  - If this was the last tile (tiles_loaded+1 == latched num_tiles), go to DONE. Otherwise go to FETCH.
  - If array_ready=0, stay in LOAD indefinitely with all outputs held.
- DONE: done=1 for exactly one cycle, then go to IDLE. w11..w22, mem_addr and tiles_loaded retain their final values until the next accepted start or reset.
- abort=1 in FETCH or LOAD: go to IDLE at the next edge with no done pulse.
  - abort takes priority over a simultaneous transfer: the tile is not counted, and tiles_loaded and mem_addr are unchanged.
  - w11..w22 retain their values.
- start outside IDLE is ignored, including during DONE. base_addr and num_tiles are don't-care except on an accepted start.
- Timing with array_ready held high:
  - start at cycle 0 gives FETCH in cycle 1 and load_weight=1 in cycle 2.
  - One tile is transferred every 2 cycles; the last transfer occurs in cycle 2N.
  - done=1 in cycle 2N+1; busy=1 in cycles 1..2N.
- Throughput: the FETCH bubble is mandatory, so load_weight is never high on two consecutive cycles.

Test Plan:
- Reset mid-LOAD with load_weight=1 -> next cycle all outputs 0, state IDLE; a subsequent start works normally.
- Memory holds 1..8 at addresses 0..7; base_addr=0, num_tiles=2, array_ready=1 -> first load cycle w11..w22 = 1,2,3,4; second load cycle w11..w22 = 5,6,7,8. done in cycle 5, tiles_loaded=2, mem_addr=8.
- Same setup with array_ready=0 for cycles 2-5, then 1 -> load_weight held with weights 1,2,3,4 through cycle 6. Transfer occurs in cycle 6, done in cycle 9.
- base_addr=8188, num_tiles=2 -> second FETCH has mem_addr=0. done pulses and mem_addr ends at 4.
- start with num_tiles=0 -> done=1 in cycle 1, load_weight never asserted, busy never asserted.
- abort in the second LOAD cycle together with array_ready=1 -> IDLE next cycle, tiles_loaded=1, no done pulse. A start pulse during busy is ignored.
